ad_result_seq: RTL and testbench

AD_RESULT_SEQ -- requirements
Module: ad_result_seq

---
 rtl/ad_result_seq_if.sv | 27 ++
 rtl/ad_result_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_ad_result_seq.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad_result_seq_if.sv
// Host read port of the A/D result sequencer: a simple pipelined read bus
// with a stall and a one-cycle-latency data-valid return path.
interface ad_result_seq_if;
  logic        host_read;
  logic [4:0]  host_address;
  logic        host_waitrequest;
  logic        host_readdatavalid;
  logic [15:0] host_readdata;

  // Host side: issues reads, observes stall and returned data.
  modport master (
    output host_read,
    output host_address,
    input  host_waitrequest,
    input  host_readdatavalid,
    input  host_readdata
  );

  // Sequencer side: accepts reads, drives stall and returned data.
  modport slave (
    input  host_read,
    input  host_address,
    output host_waitrequest,
    output host_readdatavalid,
    output host_readdata
  );
endinterface

// File: rtl/ad_result_seq.sv
// A/D result sequencer: scans NUM_CH converter channels continuously,
// stores each result (or 16'hFFFF on a conversion timeout) into a result
// RAM, and shares the RAM address port with a host read path. The channel
// write always wins the RAM port; a host read colliding with it is stalled.
module ad_result_seq #(
  parameter int NUM_CH      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               adc_start,
  output logic [4:0]         adc_chan,
  input  logic               adc_done,
  input  logic [15:0]        adc_data,
  output logic [4:0]         ram_address,
  output logic [15:0]        ram_writedata,
  output logic [1:0]         ram_writebyteenable,
  input  logic [15:0]        ram_readdata,
  ad_result_seq_if.slave     host,
  output logic               scan_done,
  output logic [7:0]         scan_count,
  output logic               timeout_err,
  input  logic               err_clear
);

  localparam logic [4:0] LAST_CH = 5'(NUM_CH - 1);
  localparam logic [7:0] TMO_CNT = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  chan_q, chan_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  count_q, count_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rdv_q, rdv_d;

  logic        timeout_s;
  logic        grant_s;
  logic        wait_s;

  // Timeout fires on the WAIT cycle whose count would reach the limit,
  // unless the converter answers in that very cycle.
  assign timeout_s = (state_q == ST_WAIT) && !adc_done &&
                     ((cnt_q + 8'd1) == TMO_CNT);

  // The RAM port belongs to the channel write in WRITE; host reads are
  // granted in every other state and held off while reset is asserted.
  assign wait_s  = host.host_read && (state_q == ST_WRITE) && !reset;
  assign grant_s = host.host_read && (state_q != ST_WRITE) && !reset;

  assign host.host_waitrequest   = wait_s;
  assign host.host_readdatavalid = rdv_q;
  assign host.host_readdata      = rdv_q ? ram_readdata : 16'd0;

  assign adc_chan    = chan_q;
  assign scan_done   = done_q;
  assign scan_count  = count_q;
  assign timeout_err = err_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one conversion per START/WAIT/WRITE round, repeated
  // while enable stays high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_START;
        else        state_d = ST_IDLE;
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (adc_done || timeout_s) state_d = ST_WRITE;
        else                       state_d = ST_WAIT;
      end
      ST_WRITE: begin
        if (enable) state_d = ST_START;
        else        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: start pulse, channel write in WRITE, host address otherwise.
  always_comb begin
    adc_start           = 1'b0;
    ram_address         = 5'd0;
    ram_writedata       = 16'd0;
    ram_writebyteenable = 2'b00;
    case (state_q)
      ST_WRITE: begin
        ram_address         = chan_q;
        ram_writedata       = hold_q;
        ram_writebyteenable = 2'b11;
      end
      default: begin
        adc_start = (state_q == ST_START);
        if (grant_s) ram_address = host.host_address;
        else         ram_address = 5'd0;
      end
    endcase
  end

  // Datapath next-state: wait counter, result hold, channel/pass tracking,
  // sticky timeout flag (a new timeout outranks a simultaneous clear).
  always_comb begin
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    count_d = count_q;
    done_d  = 1'b0;
    rdv_d   = grant_s;
    if (err_clear) err_d = 1'b0;
    else           err_d = err_q;
    case (state_q)
      ST_START: begin
        cnt_d = 8'd0;
      end
      ST_WAIT: begin
        if (adc_done) begin
          hold_d = adc_data;
        end else if (timeout_s) begin
          hold_d = 16'hFFFF;
          err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WRITE: begin
        if (chan_q == LAST_CH) begin
          chan_d  = 5'd0;
          done_d  = 1'b1;
          count_d = count_q + 8'd1;
        end else begin
          chan_d = chan_q + 5'd1;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chan_q  <= 5'd0;
      cnt_q   <= 8'd0;
      hold_q  <= 16'd0;
      count_q <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdv_q   <= rdv_d;
    end
  end

  ad_result_seq_chk u_chk (
    .clk                 (clk),
    .reset               (reset),
    .adc_start           (adc_start),
    .ram_writebyteenable (ram_writebyteenable),
    .ram_address         (ram_address),
    .host_read           (host.host_read),
    .host_address        (host.host_address),
    .host_waitrequest    (wait_s),
    .scan_done           (done_q)
  );

endmodule

// Protocol checker for the sequencer's externally visible behaviour.
module ad_result_seq_chk (
  input logic       clk,
  input logic       reset,
  input logic       adc_start,
  input logic [1:0] ram_writebyteenable,
  input logic [4:0] ram_address,
  input logic       host_read,
  input logic [4:0] host_address,
  input logic       host_waitrequest,
  input logic       scan_done
);

  // The conversion start is a single-cycle pulse.
  a_start_pulse: assert property (@(posedge clk) disable iff (reset)
    adc_start |=> !adc_start);

  // A start and a RAM write never share a cycle.
  a_start_no_write: assert property (@(posedge clk) disable iff (reset)
    !(adc_start && (ram_writebyteenable != 2'b00)));

  // A stall is only ever raised against a pending read.
  a_wait_needs_read: assert property (@(posedge clk) disable iff (reset)
    host_waitrequest |-> host_read);

  // A granted read owns the RAM address in the same cycle.
  a_grant_addr: assert property (@(posedge clk) disable iff (reset)
    (host_read && !host_waitrequest) |-> (ram_address == host_address));

  // End-of-pass is a single-cycle pulse.
  a_done_pulse: assert property (@(posedge clk) disable iff (reset)
    scan_done |=> !scan_done);

endmodule

// File: tb/tb_ad_result_seq.sv
module tb_ad_result_seq;

  localparam int NUM_CH = 4;
  localparam int TMO    = 10;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        adc_start;
  logic [4:0]  adc_chan;
  logic        adc_done;
  logic [15:0] adc_data;
  logic [4:0]  ram_address;
  logic [15:0] ram_writedata;
  logic [1:0]  ram_writebyteenable;
  logic [15:0] ram_readdata;
  logic        scan_done;
  logic [7:0]  scan_count;
  logic        timeout_err;
  logic        err_clear;

  ad_result_seq_if host_if ();

  ad_result_seq #(.NUM_CH(NUM_CH), .TIMEOUT_CYC(TMO)) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .adc_start           (adc_start),
    .adc_chan            (adc_chan),
    .adc_done            (adc_done),
    .adc_data            (adc_data),
    .ram_address         (ram_address),
    .ram_writedata       (ram_writedata),
    .ram_writebyteenable (ram_writebyteenable),
    .ram_readdata        (ram_readdata),
    .host                (host_if),
    .scan_done           (scan_done),
    .scan_count          (scan_count),
    .timeout_err         (timeout_err),
    .err_clear           (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External result RAM: synchronous, read-before-write, 1-cycle read latency.
  logic [15:0] mem [0:31];
  bit          mem_init_done;
  int          wr_count;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'd0;
      mem_init_done <= 1'b1;
      ram_readdata  <= 16'd0;
    end else begin
      ram_readdata <= mem[ram_address];
      if (ram_writebyteenable[0]) mem[ram_address][7:0]  <= ram_writedata[7:0];
      if (ram_writebyteenable[1]) mem[ram_address][15:8] <= ram_writedata[15:8];
      if (ram_writebyteenable != 2'b00) wr_count <= wr_count + 1;
    end
  end

  // Reference model: what the RAM should hold and where the scan should be.
  logic [15:0] exp_mem [0:31];
  int          exp_chan;
  logic [7:0]  exp_count;
  bit          exp_err;

  int n_tests;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_adc_start"}, adc_start, 0);
    check_eq({tag, "_adc_chan"}, adc_chan, 0);
    check_eq({tag, "_ram_address"}, ram_address, 0);
    check_eq({tag, "_ram_writedata"}, ram_writedata, 0);
    check_eq({tag, "_ram_be"}, ram_writebyteenable, 0);
    check_eq({tag, "_host_readdata"}, host_if.host_readdata, 0);
    check_eq({tag, "_waitrequest"}, host_if.host_waitrequest, 0);
    check_eq({tag, "_readdatavalid"}, host_if.host_readdatavalid, 0);
    check_eq({tag, "_scan_done"}, scan_done, 0);
    check_eq({tag, "_scan_count"}, scan_count, 0);
    check_eq({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  // One conversion from its start pulse through the cycle after its write.
  // dly > TMO means the converter never answers.
  task automatic run_conv(input int dly, input logic [15:0] data, input bit drop_en,
                          input bit hr_before, input bit hr_write, input bit clr_at_end);
    int          n;
    int          last_k;
    bit          tmo;
    bit          last;
    logic [15:0] val;
    logic [15:0] prev_word;
    n = 0;
    while (adc_start !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq("start_seen", adc_start, 1);
    if (adc_start !== 1'b1) return;
    check_eq("start_chan", adc_chan, exp_chan);
    tmo    = (dly > TMO);
    last_k = tmo ? TMO : dly;
    val    = tmo ? 16'hFFFF : data;
    for (int k = 1; k <= last_k; k++) begin
      tick();
      if (drop_en && k == 1) enable = 1'b0;
      adc_done = (!tmo && k == dly);
      adc_data = adc_done ? data : 16'($urandom);
      if (hr_before && k == last_k) begin
        host_if.host_read    = 1'b1;
        host_if.host_address = 5'(exp_chan);
      end
      if (clr_at_end && k == last_k) err_clear = 1'b1;
      @(negedge clk);
      check_eq("wait_no_start", adc_start, 0);
      check_eq("wait_no_write", ram_writebyteenable, 0);
    end
    // WRITE cycle
    tick();
    adc_done             = 1'b0;
    err_clear            = 1'b0;
    host_if.host_read    = hr_write;
    host_if.host_address = 5'd1;
    prev_word = exp_mem[exp_chan];
    if (tmo) exp_err = 1'b1;
    else if (clr_at_end) exp_err = 1'b0;
    @(negedge clk);
    check_eq("write_be", ram_writebyteenable, 2'b11);
    check_eq("write_addr", ram_address, exp_chan);
    check_eq("write_data", ram_writedata, val);
    check_eq("write_err", timeout_err, exp_err);
    if (hr_before) begin
      check_eq("pre_write_rdv", host_if.host_readdatavalid, 1);
      check_eq("pre_write_word", host_if.host_readdata, prev_word);
    end
    if (hr_write) check_eq("write_stall", host_if.host_waitrequest, 1);
    exp_mem[exp_chan] = val;
    last = (exp_chan == NUM_CH - 1);
    exp_chan = last ? 0 : exp_chan + 1;
    if (last) exp_count = exp_count + 8'd1;
    // cycle after WRITE
    tick();
    @(negedge clk);
    check_eq("scan_done", scan_done, last);
    check_eq("scan_count", scan_count, exp_count);
    check_eq("next_chan", adc_chan, exp_chan);
    check_eq("post_err", timeout_err, exp_err);
    check_eq("next_start", adc_start, enable);
    if (hr_write) begin
      check_eq("stall_release", host_if.host_waitrequest, 0);
      check_eq("grant_addr", ram_address, 5'd1);
      tick();
      host_if.host_read = 1'b0;
      @(negedge clk);
      check_eq("stalled_rdv", host_if.host_readdatavalid, 1);
      check_eq("stalled_word", host_if.host_readdata, exp_mem[1]);
    end
    if (drop_en) begin
      repeat (3) begin
        @(negedge clk);
        check_eq("idle_no_start", adc_start, 0);
      end
    end
  endtask

  // Back-to-back host reads of every channel word while the scan is idle.
  task automatic readback();
    for (int i = 0; i <= NUM_CH; i++) begin
      tick();
      host_if.host_read    = (i < NUM_CH);
      host_if.host_address = 5'(i);
      @(negedge clk);
      if (i < NUM_CH) check_eq("rb_no_stall", host_if.host_waitrequest, 0);
      if (i > 0) begin
        check_eq("rb_rdv", host_if.host_readdatavalid, 1);
        check_eq("rb_word", host_if.host_readdata, exp_mem[i - 1]);
      end
    end
  endtask

  task automatic clear_err();
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    exp_err   = 1'b0;
    @(negedge clk);
    check_eq("err_clear", timeout_err, 0);
  endtask

  // Reset pulsed during WAIT: outputs clear, nothing is written, a late
  // converter strobe is ignored.
  task automatic reset_mid_wait();
    int n;
    int wc;
    tick();
    enable = 1'b1;
    n = 0;
    while (adc_start !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_start_seen", adc_start, 1);
    tick();
    tick();
    wc = wr_count;
    reset                = 1'b1;
    enable               = 1'b0;
    host_if.host_read    = 1'b1;
    host_if.host_address = 5'd7;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    tick();
    reset             = 1'b0;
    host_if.host_read = 1'b0;
    tick();
    adc_done = 1'b1;
    adc_data = 16'hBEEF;
    tick();
    adc_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("late_done_no_start", adc_start, 0);
      check_eq("late_done_no_write", ram_writebyteenable, 0);
    end
    check_eq("rst_no_write", wr_count, wc);
    exp_chan  = 0;
    exp_count = 8'd0;
    exp_err   = 1'b0;
  endtask

  initial begin
    int  total;
    bit  drop;
    n_tests = 0;
    n_fail  = 0;
    reset                = 1'b1;
    enable               = 1'b0;
    adc_done             = 1'b0;
    adc_data             = 16'd0;
    err_clear            = 1'b0;
    host_if.host_read    = 1'b0;
    host_if.host_address = 5'd0;
    for (int i = 0; i < 32; i++) exp_mem[i] = 16'd0;
    exp_chan  = 0;
    exp_count = 8'd0;
    exp_err   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    tick();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("disabled_no_start", adc_start, 0);
    end

    // One full pass with data 1000+chan.
    tick();
    enable = 1'b1;
    for (int c = 0; c < NUM_CH; c++) run_conv(3, 16'h1000 + 16'(c), 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("pass1_count", scan_count, 8'd1);

    // Channel 2 times out; the scan carries on to channel 3.
    run_conv(3, 16'h2000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_conv(2, 16'h2001, 1'b0, 1'b0, 1'b0, 1'b0);
    run_conv(20, 16'h2002, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("tmo_flag_set", timeout_err, 1);
    run_conv(4, 16'h2003, 1'b1, 1'b0, 1'b0, 1'b0);
    readback();
    check_eq("tmo_sticky", timeout_err, 1);
    clear_err();

    // Host read colliding with WRITE, and enable dropped after the start.
    tick();
    enable = 1'b1;
    run_conv(2, 16'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_conv(5, 16'h3001, 1'b1, 1'b1, 1'b1, 1'b0);

    // Timeout coinciding with err_clear keeps the flag; a plain clear drops it.
    tick();
    enable = 1'b1;
    run_conv(20, 16'h4002, 1'b0, 1'b0, 1'b0, 1'b1);
    run_conv(3, 16'h4003, 1'b1, 1'b0, 1'b0, 1'b1);
    readback();

    // Randomised conversions.
    tick();
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drop = (i == 39) || ($urandom_range(0, 7) == 0);
      run_conv(int'($urandom_range(1, 14)), 16'($urandom), drop,
               $urandom_range(0, 3) == 0, 1'b0, $urandom_range(0, 7) == 0);
      if (drop && i != 39) begin
        tick();
        enable = 1'b1;
      end
    end
    readback();

    reset_mid_wait();

    // 256 passes from a fresh reset: the pass counter wraps back to zero.
    tick();
    enable = 1'b1;
    total = 256 * NUM_CH;
    for (int i = 0; i < total; i++) begin
      run_conv(int'($urandom_range(1, 4)), 16'($urandom), i == total - 1,
               $urandom_range(0, 3) == 0, 1'b0, 1'b0);
    end
    check_eq("scan_count_wrap", scan_count, 8'h00);
    readback();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
